// File: rtl/des_key_sched.sv
// DES key-schedule sequencer: captures PC-1(key) on accept,
// then issues the permuted key with a round index on 16 enabled beats.
module des_key_sched #(
  parameter int CHECK_PARITY = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [63:0] key_in,
  input  logic        decrypt_in,
  input  logic        key_in_valid,
  output logic        key_in_ready,
  input  logic        hold_in,
  output logic [55:0] sub_key_out,
  output logic [3:0]  sub_key_idx_out,
  output logic        sub_key_out_valid,
  output logic        last_out,
  output logic        parity_err_out
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // FIPS 46-3 PC-1, entry i feeds output bit i+1
  localparam logic [5:0] PC1 [56] = '{
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
    6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
    6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
    6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
    6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
    6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
    6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
  };

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dec_q, dec_d;
  logic [55:0] key_q, key_d;
  logic        perr_q, perr_d;
  logic [3:0]  idx_q, idx_d;
  logic        vld_q, vld_d;
  logic        last_q, last_d;

  logic [55:0] pc1;
  logic        par_bad;
  logic [5:0]  sel;
  logic [7:0]  byte_v;

  always_comb begin
    pc1 = '0;
    sel = '0;
    for (int i = 0; i < 56; i++) begin
      // 64 - n, taken modulo 64
      sel = 6'd0 - PC1[i];
      pc1[6'(55 - i)] = key_in[sel];
    end
  end

  always_comb begin
    par_bad = 1'b0;
    byte_v  = '0;
    for (int b = 0; b < 8; b++) begin
      byte_v  = 8'(key_in >> (8 * b));
      par_bad = par_bad | ~(^byte_v);
    end
  end

  assign key_in_ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    key_d   = key_q;
    perr_d  = perr_q;
    idx_d   = idx_q;
    vld_d   = 1'b0;
    last_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (key_in_valid) begin
          key_d   = pc1;
          dec_d   = decrypt_in;
          perr_d  = par_bad && (CHECK_PARITY != 0);
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!hold_in) begin
          vld_d = 1'b1;
          idx_d = dec_q ? (4'd15 - cnt_q) : cnt_q;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            last_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      key_q   <= '0;
      perr_q  <= 1'b0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      key_q   <= key_d;
      perr_q  <= perr_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

  assign sub_key_out       = key_q;
  assign sub_key_idx_out   = idx_q;
  assign sub_key_out_valid = vld_q;
  assign last_out          = last_q;
  assign parity_err_out    = perr_q;

endmodule
